// File: rtl/mdu_pkg.sv
// Shared encodings and divider constants for the multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'b000,
    MDU_MULTU = 3'b001,
    MDU_DIV   = 3'b010,
    MDU_DIVU  = 3'b011,
    MDU_MTHI  = 3'b100,
    MDU_MTLO  = 3'b101
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIX  = 2'd2
  } mdu_state_e;

  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = $clog2(DIV_ITERS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITERS - 1);

  function automatic logic [31:0] neg_if(input logic n, input logic [31:0] v);
    return n ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One combinational restoring-division step: shift {rem, quo} left, trial-subtract,
// keep the difference and set the quotient LSB when there is no borrow.
module mdu_div_step (
  input  logic [32:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] dvsr_i,
  output logic [32:0] rem_o,
  output logic [31:0] quo_o
);

  logic [32:0] shifted;
  logic [33:0] trial;
  logic        borrow;

  always_comb begin
    shifted = {rem_i[31:0], quo_i[31]};
    trial   = {1'b0, shifted} - {2'b00, dvsr_i};
    // A set remainder MSB means the shifted value exceeds any 32-bit divisor.
    borrow  = trial[33] & ~rem_i[32];
    rem_o   = borrow ? shifted : trial[32:0];
    quo_o   = {quo_i[30:0], ~borrow};
  end

endmodule

// File: rtl/mdu_hilo.sv
// HI/LO register file with MULT capture, MTHI/MTLO and a 32-step restoring divider.
// Optional macro MDU_DIV_EARLY_EN skips the iterations when the quotient is trivially 0 or all-ones.
module mdu_hilo
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic [31:0] mul_hi,
  input  logic [31:0] mul_lo,
  input  logic        cancel,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_e       state_q, state_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [32:0]      rem_q, rem_d;
  logic [31:0]      quo_q, quo_d, dvsr_q, dvsr_d;
  logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d, dz_q, dz_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        accept, is_div, div_signed, early_out;
  logic [31:0] a_mag, b_mag;
  logic [32:0] step_rem;
  logic [31:0] step_quo;

  assign accept     = (state_q == S_IDLE) & op_valid & ~cancel;
  assign is_div     = (mdu_op == MDU_DIV) | (mdu_op == MDU_DIVU);
  assign div_signed = (mdu_op == MDU_DIV);
  assign a_mag      = neg_if(div_signed & src1[31], src1);
  assign b_mag      = neg_if(div_signed & src2[31], src2);

`ifdef MDU_DIV_EARLY_EN
  assign early_out = (src2 == 32'd0) | (a_mag < b_mag);
`else
  assign early_out = 1'b0;
`endif

  mdu_div_step u_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem),
    .quo_o  (step_quo)
  );

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dz_d    = dz_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (mdu_op)
            MDU_MULT, MDU_MULTU: begin
              hi_d = mul_hi;
              lo_d = mul_lo;
            end
            MDU_MTHI: hi_d = src1;
            MDU_MTLO: lo_d = src1;
            MDU_DIV, MDU_DIVU: begin
              stall   = 1'b1;
              dvsr_d  = b_mag;
              q_neg_d = div_signed & (src1[31] ^ src2[31]);
              r_neg_d = div_signed & src1[31];
              dz_d    = (src2 == 32'd0);
              cnt_d   = '0;
              if (early_out) begin
                state_d = S_FIX;
                quo_d   = (src2 == 32'd0) ? 32'hFFFF_FFFF : 32'd0;
                rem_d   = {1'b0, a_mag};
              end else begin
                state_d = S_DIV;
                quo_d   = a_mag;
                rem_d   = '0;
              end
            end
            default: ;
          endcase
        end
      end
      S_DIV: begin
        stall = 1'b1;
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!cancel) begin
          done = 1'b1;
          // A zero divisor keeps the raw all-ones quotient; the remainder sign restores src1.
          lo_d = neg_if(q_neg_q & ~dz_q, quo_q);
          hi_d = neg_if(r_neg_q, rem_q[31:0]);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dz_q    <= dz_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed self-checking bench for mdu_hilo: MULT/MT*, divides, cancel and async reset.
module tb_mdu_hilo;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  mdu_op = 3'b000;
  logic [31:0] src1 = '0, src2 = '0, mul_hi = '0, mul_lo = '0;
  logic        cancel = 1'b0;
  logic        stall, done;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef MDU_DIV_EARLY_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  always #5 clk = ~clk;

  mdu_hilo dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .mdu_op(mdu_op),
    .src1(src1), .src2(src2), .mul_hi(mul_hi), .mul_lo(mul_lo),
    .cancel(cancel), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  // Issues one divide and waits for done; leaves the bench in the first IDLE cycle after it.
  task automatic run_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int stall_cnt, output int done_at);
    @(negedge clk);
    op_valid = 1'b1; mdu_op = op; src1 = a; src2 = b;
    #1;
    stall_cnt = (stall === 1'b1) ? 1 : 0;
    done_at = -1;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0; src1 = '0; src2 = '0;
    #1;
    for (int c = 1; c <= 100; c++) begin
      if (stall === 1'b1) stall_cnt++;
      if (done === 1'b1) begin
        done_at = c;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (done_at >= 0) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    @(negedge clk); @(negedge clk);
    #1;
    n_tests++; if (hi !== 32'd0)   begin n_fail++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
    n_tests++; if (lo !== 32'd0)   begin n_fail++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
    n_tests++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    @(negedge clk);
    reset = 1'b0;
    $display("[TB] reset released hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_mult();
    @(negedge clk);
    op_valid = 1'b1; mdu_op = MDU_MULT; mul_hi = 32'hFFFF_FFFF; mul_lo = 32'hFFFF_FFFA;
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mult_stall_accept: got %b expected 0", stall); end
    @(negedge clk);
    op_valid = 1'b0;
    #1;
    n_tests++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
    n_tests++; if (lo !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL mult_lo: got %h expected fffffffa", lo); end
    n_tests++; if (stall !== 1'b0)       begin n_fail++; $display("FAIL mult_stall_after: got %b expected 0", stall); end
    $display("[TB] MULT -> hi=%h lo=%h", hi, lo);
    @(negedge clk);
    op_valid = 1'b1; mdu_op = MDU_MULTU; mul_hi = 32'h0000_0001; mul_lo = 32'h0000_0000;
    @(negedge clk);
    op_valid = 1'b0;
    #1;
    n_tests++; if (hi !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_hi: got %h expected 00000001", hi); end
    n_tests++; if (lo !== 32'h0000_0000) begin n_fail++; $display("FAIL multu_lo: got %h expected 00000000", lo); end
    $display("[TB] MULTU -> hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_idle_guards();
    @(negedge clk);
    op_valid = 1'b1; mdu_op = 3'b110; src1 = 32'hDEAD_BEEF;
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reserved_stall: got %b expected 0", stall); end
    @(negedge clk);
    mdu_op = MDU_MULT; mul_hi = 32'h55; mul_lo = 32'h66; cancel = 1'b1;
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL cancel_mult_stall: got %b expected 0", stall); end
    @(negedge clk);
    mdu_op = MDU_DIVU; src1 = 32'd100; src2 = 32'd7;
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL cancel_div_stall: got %b expected 0", stall); end
    @(negedge clk);
    op_valid = 1'b0; cancel = 1'b0;
    #1;
    n_tests++; if (hi !== 32'h0000_0001) begin n_fail++; $display("FAIL guards_hi: got %h expected 00000001", hi); end
    n_tests++; if (lo !== 32'h0000_0000) begin n_fail++; $display("FAIL guards_lo: got %h expected 00000000", lo); end
    n_tests++; if (stall !== 1'b0)       begin n_fail++; $display("FAIL guards_no_div: got %b expected 0", stall); end
    $display("[TB] reserved/cancelled ops -> hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_divide();
    logic [2:0]  ops [8]  = '{MDU_DIVU, MDU_DIV, MDU_DIV, MDU_DIV, MDU_DIVU, MDU_DIVU, MDU_DIVU, MDU_DIV};
    logic [31:0] as  [8]  = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'd3, 32'd5, 32'hFFFF_FFFB};
    logic [31:0] bs  [8]  = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd16, 32'd10, 32'd0, 32'd0};
    logic [31:0] elo [8]  = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'h0FFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ehi [8]  = '{32'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd15, 32'd3, 32'd5, 32'hFFFF_FFFB};
    bit          fast[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int sc, da, exp_lat;
    for (int i = 0; i < 8; i++) begin
      run_div(ops[i], as[i], bs[i], sc, da);
      exp_lat = (EARLY && fast[i]) ? 1 : 33;
      n_tests++; if (sc !== exp_lat) begin n_fail++; $display("FAIL div%0d_stall_cycles: got %0d expected %0d", i, sc, exp_lat); end
      n_tests++; if (da !== exp_lat) begin n_fail++; $display("FAIL div%0d_done_cycle: got %0d expected %0d", i, da, exp_lat); end
      n_tests++; if (lo !== elo[i])  begin n_fail++; $display("FAIL div%0d_lo: got %h expected %h", i, lo, elo[i]); end
      n_tests++; if (hi !== ehi[i])  begin n_fail++; $display("FAIL div%0d_hi: got %h expected %h", i, hi, ehi[i]); end
      $display("[TB] div op=%0d %h/%h -> lo=%h hi=%h stall=%0d done@A+%0d", ops[i], as[i], bs[i], lo, hi, sc, da);
    end
  endtask

  task automatic test_back_to_back();
    int da = -1;
    int sc = 0;
    @(negedge clk);
    op_valid = 1'b1; mdu_op = MDU_DIVU; src1 = 32'd100; src2 = 32'd7;
    @(negedge clk);
    mdu_op = MDU_MTHI; src1 = 32'h0000_BEEF;
    #1;
    for (int c = 1; c <= 100; c++) begin
      if (stall === 1'b1) sc++;
      if (done === 1'b1) begin
        da = c;
        break;
      end
      @(negedge clk);
      #1;
    end
    n_tests++; if (da !== 33) begin n_fail++; $display("FAIL b2b_done_cycle: got %0d expected 33", da); end
    n_tests++; if (sc !== 32) begin n_fail++; $display("FAIL b2b_div_stall: got %0d expected 32", sc); end
    n_tests++; if (hi !== 32'hFFFF_FFFB) begin n_fail++; $display("FAIL b2b_hi_in_fix: got %h expected fffffffb", hi); end
    @(negedge clk);
    #1;
    n_tests++; if (hi !== 32'd2)   begin n_fail++; $display("FAIL b2b_div_hi: got %h expected 00000002", hi); end
    n_tests++; if (lo !== 32'd14)  begin n_fail++; $display("FAIL b2b_div_lo: got %h expected 0000000e", lo); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_stall: got %b expected 0", stall); end
    @(negedge clk);
    op_valid = 1'b0;
    #1;
    n_tests++; if (hi !== 32'h0000_BEEF) begin n_fail++; $display("FAIL b2b_mthi: got %h expected 0000beef", hi); end
    $display("[TB] DIVU then MTHI back-to-back -> hi=%h lo=%h done@A+%0d", hi, lo, da);
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    op_valid = 1'b1; mdu_op = MDU_MTHI; src1 = 32'h0000_1234;
    @(negedge clk);
    mdu_op = MDU_MTLO; src1 = 32'h0000_5678;
    #1;
    n_tests++; if (hi !== 32'h0000_1234) begin n_fail++; $display("FAIL mthi_hi: got %h expected 00001234", hi); end
    n_tests++; if (lo !== 32'd14)        begin n_fail++; $display("FAIL mthi_lo_kept: got %h expected 0000000e", lo); end
    @(negedge clk);
    op_valid = 1'b0;
    #1;
    n_tests++; if (hi !== 32'h0000_1234) begin n_fail++; $display("FAIL mtlo_hi_kept: got %h expected 00001234", hi); end
    n_tests++; if (lo !== 32'h0000_5678) begin n_fail++; $display("FAIL mtlo_lo: got %h expected 00005678", lo); end
    $display("[TB] MTHI/MTLO -> hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_cancel();
    int dones = 0;
    @(negedge clk);
    op_valid = 1'b1; mdu_op = MDU_DIV; src1 = 32'd100; src2 = 32'd7;
    @(negedge clk);
    op_valid = 1'b0;
    #1;
    for (int c = 1; c < 10; c++) begin
      if (done === 1'b1) dones++;
      @(negedge clk);
      #1;
    end
    cancel = 1'b1;
    #1;
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL cancel_stall_in_div: got %b expected 1", stall); end
    @(negedge clk);
    cancel = 1'b0;
    #1;
    n_tests++; if (stall !== 1'b0)       begin n_fail++; $display("FAIL cancel_idle: got %b expected 0", stall); end
    n_tests++; if (hi !== 32'h0000_1234) begin n_fail++; $display("FAIL cancel_hi: got %h expected 00001234", hi); end
    n_tests++; if (lo !== 32'h0000_5678) begin n_fail++; $display("FAIL cancel_lo: got %h expected 00005678", lo); end
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1) dones++;
      @(negedge clk);
      #1;
    end
    n_tests++; if (dones !== 0)          begin n_fail++; $display("FAIL cancel_no_done: got %0d expected 0", dones); end
    n_tests++; if (lo !== 32'h0000_5678) begin n_fail++; $display("FAIL cancel_lo_late: got %h expected 00005678", lo); end
    $display("[TB] DIV cancelled at A+10 -> hi=%h lo=%h dones=%0d", hi, lo, dones);
  endtask

  task automatic test_reset_mid_div();
    @(negedge clk);
    op_valid = 1'b1; mdu_op = MDU_DIVU; src1 = 32'd100; src2 = 32'd7;
    @(negedge clk);
    op_valid = 1'b0;
    for (int c = 1; c < 20; c++) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_tests++; if (hi !== 32'd0)   begin n_fail++; $display("FAIL rst_mid_hi: got %h expected 00000000", hi); end
    n_tests++; if (lo !== 32'd0)   begin n_fail++; $display("FAIL rst_mid_lo: got %h expected 00000000", lo); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall: got %b expected 0", stall); end
    @(negedge clk);
    reset = 1'b0;
    op_valid = 1'b1; mdu_op = MDU_MTLO; src1 = 32'h0000_0077;
    @(negedge clk);
    op_valid = 1'b0;
    #1;
    n_tests++; if (lo !== 32'h0000_0077) begin n_fail++; $display("FAIL rst_after_mtlo: got %h expected 00000077", lo); end
    n_tests++; if (hi !== 32'd0)         begin n_fail++; $display("FAIL rst_after_hi: got %h expected 00000000", hi); end
    $display("[TB] reset during DIVU at A+20 -> hi=%h lo=%h", hi, lo);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_idle_guards();
    test_divide();
    test_back_to_back();
    test_mthi_mtlo();
    test_cancel();
    test_reset_mid_div();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Multiply/divide sequencer and HI/LO register file for the CPU execute stage. It captures the 64-bit product from the ALU for MULT/MULTU, runs a 32-iteration restoring divider for DIV/DIVU, and services MTHI/MTLO. It stalls the pipeline while a division is in flight and drops in-flight work on exception flush.

## Interface
- No parameters; the iteration count is the constant `DIV_ITERS` = 32 in `mdu_pkg`.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `op_valid`  in  1  a valid MDU operation is presented this cycle.
- `mdu_op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 11x reserved and ignored.
- `src1`  in  32  rs operand (dividend; MTHI/MTLO data).
- `src2`  in  32  rt operand (divisor).
- `mul_hi`  in  32  ALU product bits [63:32] for the presented MULT/MULTU.
- `mul_lo`  in  32  ALU product bits [31:0].
- `cancel`  in  1  exception/ERET flush; kills the current op.
- `stall`  out  1  hold the issuing stage; combinational.
- `done`  out  1  one-cycle pulse when a division writes HI/LO.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- The FSM has three states: IDLE, DIV, FIX. Operations are accepted only in IDLE with `op_valid & ~cancel`.
- MULT/MULTU: on accept, HI←`mul_hi` and LO←`mul_lo` at the clock edge. No stall.
- MTHI/MTLO: HI (or LO)←`src1` at the edge; the other register is unchanged. No stall.
- DIV/DIVU accept:
  - latch |src1| and |src2| (for DIVU, the raw values);
  - latch `q_neg` = src1[31]^src2[31] and `r_neg` = src1[31] (both 0 for DIVU);
  - clear the 33-bit partial remainder and iteration counter; go to DIV.
- DIV: one restoring step per cycle.
  - Shift {rem, quo} left by 1 and trial-subtract the divisor from the remainder.
  - If there is no borrow, keep the difference and set the quotient LSB to 1.
  - After 32 steps, go to FIX.
- FIX:
  - LO←`q_neg` ? −quo : quo; HI←`r_neg` ? −rem : rem;
  - assert `done`; return to IDLE;
  - `op_valid` is ignored in FIX.
- Divide by zero: LO = 32'hFFFFFFFF and HI = src1, regardless of signedness, with no exception. This falls out of the restoring algorithm; for signed divides the FIX sign correction is suppressed in this case.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- `stall` = (state==DIV) | (state==IDLE & op_valid & ~cancel & mdu_op∈{DIV,DIVU}). It is low in FIX, so the issuing instruction advances in the FIX cycle.
- `cancel`:
  - in DIV or FIX, go to IDLE next edge; HI/LO unchanged; no `done`;
  - in IDLE, block acceptance that cycle.
  - `cancel` has priority over every other event.
- Reserved `mdu_op` values: no state change, no stall.

## Timing
- Reset state: state IDLE; `hi` = 0, `lo` = 0; `done` = 0; `stall` = 0 (given `op_valid` = 0); divider registers 0.
- MULT/MULTU/MTHI/MTLO: result is visible on `hi`/`lo` the cycle after accept.
- DIV/DIVU without the early-out feature:
  - accept cycle is A;
  - DIV occupies A+1..A+32;
  - FIX is A+33, with `done` high;
  - result is visible at A+34;
  - `stall` is high in cycles A..A+32, i.e. 33 cycles.
- Back-to-back operations: a new op can be accepted no earlier than A+34 (the first IDLE cycle).
- `hi`/`lo` are plain registers with no internal forwarding. MFHI/MFLO in the cycle an update lands read the old value; the pipeline interlocks on this.
- Reset asserted mid-division: immediate return to IDLE with HI/LO = 0.

## Configuration
- `MDU_DIV_EARLY_EN` defined:
  - on DIV/DIVU accept, if divisor = 0 or |src1| < |src2| (unsigned compare of magnitudes), go directly to FIX;
  - quotient = 0 (or all-ones for a zero divisor) and remainder = |src1|, with sign correction as normal;
  - `stall` is high only in the accept cycle; `done` occurs at A+1.
- `MDU_DIV_EARLY_EN` undefined: every division takes the full 32 DIV cycles.

## Structure
- `mdu_pkg` holds:
  - the `mdu_op` encodings (MDU_MULT … MDU_MTLO);
  - the state encodings (S_IDLE, S_DIV, S_FIX);
  - `DIV_ITERS`.
- One sub-module, `mdu_div_step`: combinational single restoring step.
  - Inputs: 33-bit remainder, 32-bit quotient, 32-bit divisor.
  - Outputs: next remainder and next quotient.
- The FSM, counter, sign handling and HI/LO registers stay in `mdu_hilo`.

## Test plan
- MULT with mul_hi=0xFFFFFFFF, mul_lo=0xFFFFFFFA (−3×2) → next cycle hi=0xFFFFFFFF, lo=0xFFFFFFFA, `stall` never high.
- DIVU 100/7 → `stall` high for 33 cycles, `done` at A+33, then lo=14, hi=2.
- DIV −7/2 (0xFFFFFFF9, 2) → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 5/0 → lo=0xFFFFFFFF, hi=5. With `MDU_DIV_EARLY_EN`, the same result with `done` at A+1.
- MTHI 0x1234 then MTLO 0x5678 → hi=0x1234, lo=0x5678. Then DIV with `cancel` pulsed at A+10 → state IDLE at A+11, hi/lo unchanged, no `done`.
- `reset` asserted at A+20 of a DIVU → hi=lo=0, `stall`=0, state IDLE asynchronously.
